sdram_pro_port_arb: RTL

SDRAM_PRO_PORT_ARB -- requirements
Module: sdram_pro_port_arb

---
 rtl/sdram_pro_pkg.sv | 36 +++
 rtl/sdram_pro_rr_sel.sv | 31 +++
 rtl/sdram_pro_port_arb.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/sdram_pro_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pro_pkg
// Shared definitions for the two-client SDRAM port arbiter.
//   ADDR_W / LEN_W / DATA_W : default SDRAM word-address, burst-length and
//                             data widths.
//   slot_t                  : fixed request-slot numbering. Bit 0 of a slot
//                             is the transfer type (1 = read). Bit 1 is the
//                             client number.
//   arb_state_t             : arbiter FSM states.
//   client_mask()           : one-hot 2-bit mask selecting a client's bit.
// -----------------------------------------------------------------------------
package sdram_pro_pkg;

    localparam int ADDR_W    = 23;
    localparam int LEN_W     = 8;
    localparam int DATA_W    = 16;
    localparam int NUM_SLOTS = 4;

    typedef enum logic [1:0] {
        SLOT_C0_WR = 2'd0,
        SLOT_C0_RD = 2'd1,
        SLOT_C1_WR = 2'd2,
        SLOT_C1_RD = 2'd3
    } slot_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    function automatic logic [1:0] client_mask(input logic client);
        return client ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sdram_pro_rr_sel.sv
// -----------------------------------------------------------------------------
// sdram_pro_rr_sel
// Purely combinational round-robin picker over the four request slots.
//   req   [3:0] : per-slot request levels (slot numbering from sdram_pro_pkg)
//   ptr   [1:0] : slot with highest priority this round
//   valid       : at least one slot is requesting
//   idx   [1:0] : first requesting slot at or after ptr, wrapping 3 -> 0
// -----------------------------------------------------------------------------
module sdram_pro_rr_sel
    import sdram_pro_pkg::*;
(
    input  logic [NUM_SLOTS-1:0] req,
    input  logic [1:0]           ptr,
    output logic                 valid,
    output logic [1:0]           idx
);

    // Scan offsets from farthest to nearest so the nearest requester is the
    // last one written. The 2-bit sum wraps naturally from slot 3 to slot 0.
    always_comb begin
        valid = 1'b0;
        idx   = ptr;
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) begin
                valid = 1'b1;
                idx   = ptr + 2'(k);
            end
        end
    end

endmodule

// File: rtl/sdram_pro_port_arb.sv
// -----------------------------------------------------------------------------
// sdram_pro_port_arb
// Shares a single SDRAM controller between two clients. Each client has a
// write port and a read port, which gives four request slots. The slots are
// served round-robin, and the controller sees one burst at a time.
//
// Ports
//   sys_clk, sys_rst_n          : clock, synchronous active-low reset
//   init_end                    : SDRAM initialised; new grants wait for it
//   c_wr_req / c_rd_req   [1:0] : client request levels (client n in bit n)
//   c_wr_addr / c_rd_addr       : packed start addresses, client 0 low field
//   c_wr_len / c_rd_len         : packed burst lengths, client 0 low field
//   c_wr_data                   : packed write data, client 0 low field
//   c_rd_data                   : read data broadcast while a read is active
//   c_wr_ack / c_rd_ack   [1:0] : controller ack, routed to the owner only
//   c_wr_end / c_rd_end   [1:0] : one-cycle burst-complete pulse to the owner
//   sdram_wr_req/addr, wr_burst_len, sdram_data_in : controller write side
//   sdram_rd_req/addr, rd_burst_len                : controller read side
//   sdram_wr_ack/end, sdram_rd_ack/end, sdram_data_out : controller responses
// -----------------------------------------------------------------------------
module sdram_pro_port_arb #(
    parameter int ADDR_W = sdram_pro_pkg::ADDR_W,
    parameter int LEN_W  = sdram_pro_pkg::LEN_W,
    parameter int DATA_W = sdram_pro_pkg::DATA_W
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  init_end,

    input  logic [1:0]            c_wr_req,
    input  logic [1:0]            c_rd_req,
    input  logic [2*ADDR_W-1:0]   c_wr_addr,
    input  logic [2*ADDR_W-1:0]   c_rd_addr,
    input  logic [2*LEN_W-1:0]    c_wr_len,
    input  logic [2*LEN_W-1:0]    c_rd_len,
    input  logic [2*DATA_W-1:0]   c_wr_data,
    output logic [DATA_W-1:0]     c_rd_data,
    output logic [1:0]            c_wr_ack,
    output logic [1:0]            c_rd_ack,
    output logic [1:0]            c_wr_end,
    output logic [1:0]            c_rd_end,

    output logic                  sdram_wr_req,
    output logic [ADDR_W-1:0]     sdram_wr_addr,
    output logic [LEN_W-1:0]      wr_burst_len,
    output logic [DATA_W-1:0]     sdram_data_in,
    output logic                  sdram_rd_req,
    output logic [ADDR_W-1:0]     sdram_rd_addr,
    output logic [LEN_W-1:0]      rd_burst_len,
    input  logic                  sdram_wr_ack,
    input  logic                  sdram_wr_end,
    input  logic                  sdram_rd_ack,
    input  logic                  sdram_rd_end,
    input  logic [DATA_W-1:0]     sdram_data_out
);

    import sdram_pro_pkg::*;

    arb_state_t        state, state_nxt;
    logic [1:0]        owner, owner_nxt;
    logic [1:0]        rr_ptr, rr_ptr_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [LEN_W-1:0]  len_q, len_nxt;
    logic [1:0]        wr_end_q, wr_end_nxt;
    logic [1:0]        rd_end_q, rd_end_nxt;

    logic [NUM_SLOTS-1:0] slot_req;
    logic                 sel_valid;
    logic [1:0]           sel_idx;
    logic [ADDR_W-1:0]    sel_addr;
    logic [LEN_W-1:0]     sel_len;

    logic owner_rd;
    logic owner_client;
    logic busy_wr;
    logic busy_rd;
    logic burst_end;

    assign slot_req = {c_rd_req[1], c_wr_req[1], c_rd_req[0], c_wr_req[0]};

    sdram_pro_rr_sel u_rr_sel (
        .req   (slot_req),
        .ptr   (rr_ptr),
        .valid (sel_valid),
        .idx   (sel_idx)
    );

    // Address and length of the slot the picker currently favours. These are
    // captured only on the grant edge.
    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        case (sel_idx)
            SLOT_C0_WR: begin
                sel_addr = c_wr_addr[0 +: ADDR_W];
                sel_len  = c_wr_len[0 +: LEN_W];
            end
            SLOT_C0_RD: begin
                sel_addr = c_rd_addr[0 +: ADDR_W];
                sel_len  = c_rd_len[0 +: LEN_W];
            end
            SLOT_C1_WR: begin
                sel_addr = c_wr_addr[ADDR_W +: ADDR_W];
                sel_len  = c_wr_len[LEN_W +: LEN_W];
            end
            default: begin
                sel_addr = c_rd_addr[ADDR_W +: ADDR_W];
                sel_len  = c_rd_len[LEN_W +: LEN_W];
            end
        endcase
    end

    assign owner_rd     = owner[0];
    assign owner_client = owner[1];
    assign busy_wr      = (state == BUSY) && !owner_rd;
    assign busy_rd      = (state == BUSY) &&  owner_rd;

    // Only an end strobe that matches the owner's transfer type closes a burst.
    assign burst_end = (busy_wr && sdram_wr_end) || (busy_rd && sdram_rd_end);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            owner    <= 2'd0;
            rr_ptr   <= 2'd0;
            addr_q   <= '0;
            len_q    <= '0;
            wr_end_q <= 2'b00;
            rd_end_q <= 2'b00;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_ptr_nxt;
            addr_q   <= addr_nxt;
            len_q    <= len_nxt;
            wr_end_q <= wr_end_nxt;
            rd_end_q <= rd_end_nxt;
        end
    end

    // The end pulses are registered. They therefore always appear in the
    // single DONE cycle, both after a real burst and after a zero-length grant.
    // A zero-length grant never reaches the controller: it jumps straight to
    // DONE and advances the pointer there.
    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        rr_ptr_nxt = rr_ptr;
        addr_nxt   = addr_q;
        len_nxt    = len_q;
        wr_end_nxt = 2'b00;
        rd_end_nxt = 2'b00;

        case (state)
            IDLE: begin
                if (init_end && sel_valid) begin
                    owner_nxt = sel_idx;
                    addr_nxt  = sel_addr;
                    len_nxt   = sel_len;
                    if (sel_len == '0) begin
                        state_nxt  = DONE;
                        rr_ptr_nxt = sel_idx + 2'd1;
                        if (sel_idx[0]) begin
                            rd_end_nxt = client_mask(sel_idx[1]);
                        end else begin
                            wr_end_nxt = client_mask(sel_idx[1]);
                        end
                    end else begin
                        state_nxt = BUSY;
                    end
                end
            end

            BUSY: begin
                if (burst_end) begin
                    state_nxt  = DONE;
                    rr_ptr_nxt = owner + 2'd1;
                    if (owner_rd) begin
                        rd_end_nxt = client_mask(owner_client);
                    end else begin
                        wr_end_nxt = client_mask(owner_client);
                    end
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Controller-facing outputs. The request is qualified by the owner's
    // transfer type, so at most one request line is ever high.
    assign sdram_wr_req  = busy_wr;
    assign sdram_rd_req  = busy_rd;
    assign sdram_wr_addr = addr_q;
    assign sdram_rd_addr = addr_q;
    assign wr_burst_len  = len_q;
    assign rd_burst_len  = len_q;

    // Data and acks are passed through combinationally, but only while the
    // owner's burst is live. Everything else therefore sees zeros.
    assign sdram_data_in = busy_wr ? c_wr_data[(owner_client ? DATA_W : 0) +: DATA_W] : '0;
    assign c_rd_data     = busy_rd ? sdram_data_out : '0;
    assign c_wr_ack      = (busy_wr && sdram_wr_ack) ? client_mask(owner_client) : 2'b00;
    assign c_rd_ack      = (busy_rd && sdram_rd_ack) ? client_mask(owner_client) : 2'b00;
    assign c_wr_end      = wr_end_q;
    assign c_rd_end      = rd_end_q;

endmodule
